// File: rtl/led_pattern_gen_pkg.sv
// Shared types and helpers for the LED pattern generator.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_BIN  = 2'd0,
        MODE_GRAY = 2'd1,
        MODE_SCAN = 2'd2,
        MODE_ALT  = 2'd3
    } led_mode_t;

    localparam int MAX_LEDS = 16;

    // Alternating pattern 0101..., bit 0 set. Bits at or above width are cleared.
    function automatic logic [MAX_LEDS-1:0] alt_mask(input int width);
        logic [MAX_LEDS-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LEDS; i++) begin
            m[i] = (i < width) && ((i % 2) == 0);
        end
        return m;
    endfunction

endpackage

// File: rtl/led_pattern_gen_scanner.sv
// Bouncing scanner: position plus direction, one-hot output.
// The one-hot output reflects the position the scanner holds after the
// current edge, so the parent can register the pattern with no extra latency.
module led_scanner
    import led_pattern_pkg::*;
#(
    parameter int NUM_LEDS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                advance,
    input  logic                clear,
    output logic [NUM_LEDS-1:0] onehot
);

    localparam int             PW   = $clog2(NUM_LEDS);
    localparam logic [PW-1:0]  LAST = PW'(NUM_LEDS - 1);

    logic [PW-1:0] pos_q, pos_d;
    logic          down_q, down_d;

    // Next position: bounce at both ends, each end held for one step.
    always_comb begin
        pos_d  = pos_q;
        down_d = down_q;
        if (clear) begin
            pos_d  = '0;
            down_d = 1'b0;
        end else if (advance) begin
            if (!down_q && pos_q == LAST) begin
                down_d = 1'b1;
                pos_d  = LAST - 1'b1;
            end else if (down_q && pos_q == '0) begin
                down_d = 1'b0;
                pos_d  = PW'(1);
            end else if (down_q) begin
                pos_d  = pos_q - 1'b1;
            end else begin
                pos_d  = pos_q + 1'b1;
            end
        end
    end

    // Scanner state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q  <= '0;
            down_q <= 1'b0;
        end else begin
            pos_q  <= pos_d;
            down_q <= down_d;
        end
    end

    assign onehot = NUM_LEDS'(1) << pos_d;

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: shared prescaler, step counter, runtime mode select
// (binary, Gray, bouncing scanner, alternating).
// Optional PWM brightness gating when LED_PWM_EN is defined.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int NUM_LEDS  = 5,
    parameter int LOG2DELAY = 22,
    parameter int PWM_BITS  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode,
`ifdef LED_PWM_EN
    input  logic [PWM_BITS-1:0] brightness,
`endif
    output logic [NUM_LEDS-1:0] led,
    output logic                tick
);

    localparam logic [MAX_LEDS-1:0] ALT_FULL = alt_mask(NUM_LEDS);
    localparam logic [NUM_LEDS-1:0] ALT      = ALT_FULL[NUM_LEDS-1:0];

    logic [LOG2DELAY-1:0] pre_q;
    logic [NUM_LEDS-1:0]  step_q, step_d;
    led_mode_t            mode_q, mode_d;
    logic                 mode_chg;
    logic [NUM_LEDS-1:0]  scan_oh;
    logic [NUM_LEDS-1:0]  pat;
    logic [NUM_LEDS-1:0]  pat_gated;

    assign tick = &pre_q;

    // Mode is sampled only on a tick; a new mode restarts the sequence.
    always_comb begin
        mode_d   = mode_q;
        step_d   = step_q;
        mode_chg = 1'b0;
        if (tick) begin
            mode_d   = led_mode_t'(mode);
            mode_chg = (mode_d != mode_q);
            step_d   = mode_chg ? '0 : step_q + 1'b1;
        end
    end

    led_scanner #(.NUM_LEDS(NUM_LEDS)) u_scan (
        .clk     (clk),
        .rst     (rst),
        .advance (tick),
        .clear   (mode_chg),
        .onehot  (scan_oh)
    );

    // Pattern evaluated on post-edge state so led tracks tick with one cycle latency.
    always_comb begin
        pat = '0;
        case (mode_d)
            MODE_BIN:  pat = step_d;
            MODE_GRAY: pat = step_d ^ (step_d >> 1);
            MODE_SCAN: pat = scan_oh;
            MODE_ALT:  pat = step_d[0] ? ~ALT : ALT;
            default:   pat = '0;
        endcase
    end

`ifdef LED_PWM_EN
    logic pwm_on;
    assign pwm_on    = (pre_q[PWM_BITS-1:0] < brightness);
    assign pat_gated = pat & {NUM_LEDS{pwm_on}};
`else
    assign pat_gated = pat;
`endif

    // Prescaler, step counter, mode register and LED drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q  <= '0;
            step_q <= '0;
            mode_q <= MODE_BIN;
            led    <= '0;
        end else begin
            pre_q  <= pre_q + 1'b1;
            step_q <= step_d;
            mode_q <= mode_d;
            led    <= pat_gated;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with NUM_LEDS=4, LOG2DELAY=2.
// PWM scenarios are compiled in only when LED_PWM_EN is defined.
module tb_led_pattern_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'd0;
`ifdef LED_PWM_EN
    logic [1:0] brightness = 2'd3;
`endif
    logic [3:0] led;
    logic       tick;

    int n_tests = 0;
    int n_fail  = 0;

    led_pattern_gen #(.NUM_LEDS(4), .LOG2DELAY(2), .PWM_BITS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
`ifdef LED_PWM_EN
        .brightness (brightness),
`endif
        .led        (led),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    // Pulse reset across one rising edge; returns at the negedge of cycle 0.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Advance negedge by negedge until tick is seen (bounded).
    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        mode = 2'd0;
        do_reset();
        n_tests++;
        if (led !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_led: got %b want 0000", led);
        end
        n_tests++;
        if (tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tick: got %b want 0", tick);
        end
    endtask

    task automatic test_binary();
        logic       exp_tick;
        logic [3:0] exp_led;
        mode = 2'd0;
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) @(negedge clk);
            exp_tick = ((c % 4) == 3);
            exp_led  = 4'(c / 4);
            n_tests++;
            if (tick !== exp_tick) begin
                n_fail++;
                $display("FAIL bin_tick c=%0d: got %b want %b", c, tick, exp_tick);
            end
            n_tests++;
            if (led !== exp_led) begin
                n_fail++;
                $display("FAIL bin_led c=%0d: got %b want %b", c, led, exp_led);
            end
        end
    endtask

    task automatic test_gray();
        logic [3:0] exp [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                                 4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                 4'b1011, 4'b1001, 4'b1000, 4'b0000};
        bit ok;
        mode = 2'd1;
        do_reset();
        wait_tick(ok);
        @(negedge clk);
        n_tests++;
        if (!ok || led !== 4'b0000) begin
            n_fail++;
            $display("FAIL gray_load: ok=%0d got %b want 0000", ok, led);
        end
        for (int k = 0; k < 16; k++) begin
            wait_tick(ok);
            @(negedge clk);
            n_tests++;
            if (!ok || led !== exp[k]) begin
                n_fail++;
                $display("FAIL gray_step%0d: ok=%0d got %b want %b", k + 1, ok, led, exp[k]);
            end
        end
    endtask

    task automatic test_scanner();
        logic [3:0] exp [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                4'b0100, 4'b0010, 4'b0001, 4'b0010};
        bit ok;
        mode = 2'd2;
        for (int k = 0; k < 8; k++) begin
            wait_tick(ok);
            @(negedge clk);
            n_tests++;
            if (!ok || led !== exp[k]) begin
                n_fail++;
                $display("FAIL scan_step%0d: ok=%0d got %b want %b", k, ok, led, exp[k]);
            end
        end
    endtask

    task automatic test_alt_switch();
        bit ok;
        mode = 2'd0;
        wait_tick(ok);
        @(negedge clk);
        wait_tick(ok);
        @(negedge clk);
        n_tests++;
        if (!ok || led !== 4'b0001) begin
            n_fail++;
            $display("FAIL alt_pre: ok=%0d got %b want 0001", ok, led);
        end
        // Mid-interval changes, including a transient value, must not show early.
        mode = 2'd3;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) mode = 2'd1;
            if (c == 2) mode = 2'd3;
            n_tests++;
            if (led !== 4'b0001) begin
                n_fail++;
                $display("FAIL alt_hold c=%0d: got %b want 0001", c, led);
            end
        end
        n_tests++;
        if (tick !== 1'b1) begin
            n_fail++;
            $display("FAIL alt_tick: got %b want 1", tick);
        end
        @(negedge clk);
        n_tests++;
        if (led !== 4'b0101) begin
            n_fail++;
            $display("FAIL alt_first: got %b want 0101", led);
        end
        wait_tick(ok);
        @(negedge clk);
        n_tests++;
        if (!ok || led !== 4'b1010) begin
            n_fail++;
            $display("FAIL alt_second: ok=%0d got %b want 1010", ok, led);
        end
        wait_tick(ok);
        @(negedge clk);
        n_tests++;
        if (!ok || led !== 4'b0101) begin
            n_fail++;
            $display("FAIL alt_same_mode: ok=%0d got %b want 0101", ok, led);
        end
    endtask

    task automatic test_rst_on_tick();
        bit ok;
        mode = 2'd2;
        for (int k = 0; k < 4; k++) begin
            wait_tick(ok);
            @(negedge clk);
        end
        wait_tick(ok);
        n_tests++;
        if (!ok || led !== 4'b1000) begin
            n_fail++;
            $display("FAIL rst_setup: ok=%0d got %b want 1000", ok, led);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if (led !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_led: got %b want 0000", led);
        end
        for (int c = 0; c <= 3; c++) begin
            if (c > 0) @(negedge clk);
            n_tests++;
            if (tick !== (c == 3)) begin
                n_fail++;
                $display("FAIL rst_tick c=%0d: got %b want %b", c, tick, (c == 3));
            end
        end
        @(negedge clk);
        n_tests++;
        if (led !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_reload: got %b want 0001", led);
        end
    endtask

`ifdef LED_PWM_EN
    task automatic test_pwm();
        logic [1:0] bvals [3] = '{2'd1, 2'd0, 2'd3};
        int         exp_on [3] = '{1, 0, 3};
        bit ok;
        int on_cnt, bad_cnt;
        mode = 2'd0;
        brightness = 2'd1;
        do_reset();
        for (int idx = 0; idx < 3; idx++) begin
            brightness = bvals[idx];
            for (int t = 0; t < ((idx == 0) ? 15 : 16); t++) begin
                wait_tick(ok);
                if (!ok) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL pwm_tick_timeout b=%0d", bvals[idx]);
                end
                @(negedge clk);
            end
            on_cnt  = 0;
            bad_cnt = 0;
            for (int w = 0; w < 4; w++) begin
                if (led === 4'b1111) on_cnt++;
                else if (led !== 4'b0000) bad_cnt++;
                if (w < 3) @(negedge clk);
            end
            n_tests++;
            if (on_cnt != exp_on[idx]) begin
                n_fail++;
                $display("FAIL pwm_duty b=%0d: got %0d on-cycles want %0d", bvals[idx], on_cnt, exp_on[idx]);
            end
            n_tests++;
            if (bad_cnt != 0) begin
                n_fail++;
                $display("FAIL pwm_shape b=%0d: got %0d bad cycles want 0", bvals[idx], bad_cnt);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_binary();
        test_gray();
        test_scanner();
        test_alt_switch();
        test_rst_on_tick();
`ifdef LED_PWM_EN
        test_pwm();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
